// File: rtl/mult_seq_pkg.sv
// Shared types for the sequential shift-add multiplier.
package mult_seq_pkg;

`include "mult_seq_defs.vh"

    typedef enum logic [1:0] {
        S_IDLE = `ST_IDLE,
        S_RUN  = `ST_RUN,
        S_DONE = `ST_DONE
    } state_t;

endpackage

// File: rtl/mult_seq_addsub.sv
// WIDTH-bit ripple adder with carry in/out and optional inversion of b.
module mult_seq_addsub #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] bx;

    assign carry[0] = cin;
    assign bx       = sub ? ~b : b;

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
            assign sum[gi]     = a[gi] ^ bx[gi] ^ carry[gi];
            assign carry[gi+1] = (a[gi] & bx[gi]) | (a[gi] & carry[gi]) | (bx[gi] & carry[gi]);
        end
    endgenerate

    assign cout = carry[WIDTH];

endmodule

// File: rtl/mult_seq_defs.vh
// State encodings shared by the sequential multiplier slice.
`ifndef MULT_SEQ_DEFS_VH
`define MULT_SEQ_DEFS_VH

`define ST_IDLE 2'd0
`define ST_RUN  2'd1
`define ST_DONE 2'd2

`endif

// File: rtl/mult_seq_ctrl.sv
// Sequential shift-add multiplier: one adder reused over WIDTH cycles, start/done handshake.
// Define MULT_SEQ_SIGNED_EN for two's-complement operands and product.
module mult_seq_ctrl
    import mult_seq_pkg::*;
#(
    parameter  int WIDTH = 8,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    output logic               ready,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] P
);

    state_t             state_reg, state_next;
    logic [WIDTH-1:0]   m_reg;
    logic [WIDTH:0]     acc_reg;
    logic [WIDTH-1:0]   q_reg;
    logic [CNT_W-1:0]   count_reg;
    logic [2*WIDTH-1:0] p_reg;

    logic               load, step, last;
    logic               sub;
    logic [WIDTH-1:0]   add_b, sum;
    logic               cout, sum_top, fill;
    logic [WIDTH:0]     acc_step;
    logic [WIDTH-1:0]   q_step;

    assign last  = (count_reg == CNT_W'(WIDTH - 1));
    assign add_b = q_reg[0] ? m_reg : '0;

`ifdef MULT_SEQ_SIGNED_EN
    // The last multiplier bit carries negative weight, so it subtracts M.
    assign sub     = last & q_reg[0];
    assign sum_top = acc_reg[WIDTH] ^ add_b[WIDTH-1] ^ sub ^ cout;
    assign fill    = sum_top;
`else
    assign sub     = 1'b0;
    assign sum_top = acc_reg[WIDTH] ^ cout;
    assign fill    = 1'b0;
`endif

    mult_seq_addsub #(.WIDTH(WIDTH)) u_addsub (
        .a    (acc_reg[WIDTH-1:0]),
        .b    (add_b),
        .sub  (sub),
        .cin  (sub),
        .sum  (sum),
        .cout (cout)
    );

    // {ACC,Q} shifted right by one after the conditional add.
    assign acc_step = {fill, sum_top, sum[WIDTH-1:1]};
    assign q_step   = {sum[0], q_reg[WIDTH-1:1]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = S_IDLE;
        load       = 1'b0;
        step       = 1'b0;
        ready      = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state_reg)
            S_IDLE: begin
                ready = 1'b1;
                if (start) begin
                    load       = 1'b1;
                    state_next = S_RUN;
                end
            end
            S_RUN: begin
                busy       = 1'b1;
                step       = 1'b1;
                state_next = last ? S_DONE : S_RUN;
            end
            S_DONE: begin
                ready = 1'b1;
                done  = 1'b1;
                if (start) begin
                    load       = 1'b1;
                    state_next = S_RUN;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_reg     <= '0;
            acc_reg   <= '0;
            q_reg     <= '0;
            count_reg <= '0;
            p_reg     <= '0;
        end else if (load) begin
            m_reg     <= A;
            acc_reg   <= '0;
            q_reg     <= B;
            count_reg <= '0;
        end else if (step) begin
            acc_reg   <= acc_step;
            q_reg     <= q_step;
            count_reg <= count_reg + CNT_W'(1);
            if (last) begin
                p_reg <= {acc_step[WIDTH-1:0], q_step};
            end
        end
    end

    assign P = p_reg;

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Scoreboard bench for mult_seq_ctrl: driver pushes expected products, monitor checks on done.
module tb_mult_seq_ctrl;

    localparam int W = 8;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           start = 1'b0;
    logic [W-1:0]   a_in = '0;
    logic [W-1:0]   b_in = '0;
    logic           ready, busy, done;
    logic [2*W-1:0] p;

    mult_seq_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .A     (a_in),
        .B     (b_in),
        .ready (ready),
        .busy  (busy),
        .done  (done),
        .P     (p)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] prod;
        int          due;
    } exp_t;

    exp_t        sb[$];
    int          cyc = 0;
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [15:0] last_p = '0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] model(input logic [7:0] a, input logic [7:0] b);
        longint prod;
`ifdef MULT_SEQ_SIGNED_EN
        prod = longint'($signed(a)) * longint'($signed(b));
`else
        prod = longint'(a) * longint'(b);
`endif
        return prod[15:0];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: compares against the scoreboard whenever done is presented.
    always @(negedge clk) begin
        if (!rst) begin
            if (done) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_done: got done=1 expected none (cycle %0d)", cyc);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("product", 32'(p), 32'(e.prod));
                    check("done_cycle", cyc, e.due);
                    $display("op done: P=%04h expected %04h at cycle %0d", p, e.prod, cyc);
                end
                last_p = p;
            end else begin
                check("p_hold", 32'(p), 32'(last_p));
                if (sb.size() > 0 && cyc > sb[0].due) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL missing_done: got no done expected at cycle %0d", sb[0].due);
                    void'(sb.pop_front());
                end
            end
        end
    end

    task automatic do_op(input logic [7:0] a, input logic [7:0] b);
        int   t;
        exp_t e;
        t = 0;
        @(negedge clk);
        while (!ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!ready) begin
            n_cmp++;
            n_bad++;
            $display("FAIL ready_timeout: got ready=0 expected 1 within 50 cycles");
            return;
        end
        start  = 1'b1;
        a_in   = a;
        b_in   = b;
        e.prod = model(a, b);
        e.due  = cyc + 1 + W;
        sb.push_back(e);
        $display("op issue: A=%02h B=%02h expect %04h", a, b, e.prod);
        @(posedge clk);
        #1;
        start = 1'b0;
        a_in  = W'($urandom);
        b_in  = W'($urandom);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        #1 rst = 1'b1;
        repeat (2) @(negedge clk);
        check("reset_p", 32'(p), 32'h0);
        check("reset_ready", 32'(ready), 32'h1);
        check("reset_busy", 32'(busy), 32'h0);
        check("reset_done", 32'(done), 32'h0);
        rst = 1'b0;

        // Single op, then confirm idle handshake and held product.
        do_op(8'd13, 8'd11);
        repeat (10) @(negedge clk);
        check("idle_ready", 32'(ready), 32'h1);
        check("idle_busy", 32'(busy), 32'h0);
        check("idle_p", 32'(p), 32'h008F);

        do_op(8'hFF, 8'hFF);
        do_op(8'h00, 8'hA5);

        // Back-to-back: second start lands in the DONE cycle.
        repeat (12) @(negedge clk);
        do_op(8'd3, 8'd4);
        do_op(8'd7, 8'd9);

        // Start pulse while busy must be ignored.
        repeat (12) @(negedge clk);
        do_op(8'd2, 8'd5);
        repeat (3) @(negedge clk);
        check("busy_mid_run", 32'(busy), 32'h1);
        start = 1'b1;
        a_in  = 8'd1;
        b_in  = 8'd1;
        @(posedge clk);
        #1 start = 1'b0;

        // Asynchronous reset between edges during RUN.
        repeat (12) @(negedge clk);
        do_op(8'h55, 8'h33);
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        sb.delete();
        last_p = '0;
        #1;
        check("async_rst_p", 32'(p), 32'h0);
        check("async_rst_busy", 32'(busy), 32'h0);
        check("async_rst_ready", 32'(ready), 32'h1);
        @(negedge clk);
        rst = 1'b0;
        repeat (12) @(negedge clk);
        do_op(8'd6, 8'd7);

        // Signed corner operands (also valid unsigned vectors).
        do_op(8'hFD, 8'h05);
        do_op(8'h80, 8'h80);
        do_op(8'h7F, 8'hFF);

        for (int i = 0; i < 40; i++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            do_op(8'($urandom), 8'($urandom));
        end

        repeat (W + 4) @(negedge clk);
        check("scoreboard_empty", 32'(sb.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
